// File: rtl/regfile_pkg.sv
// Shared constants for the sMIPS register file: bus widths, reset/write
// polarities and the zero word.
package regfile_pkg;

   localparam int RegDataBus = 32;
   localparam int RegAddrBus = 5;
   localparam int RegNum     = 32;
   localparam int RegNumLog2 = 5;

   // Reset is active-low for this block.
   localparam logic RstEnable    = 1'b0;
   localparam logic WriteEnable  = 1'b1;
   localparam logic WriteDisable = 1'b0;

   localparam logic [RegDataBus-1:0] ZeroWord   = '0;
   localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

endpackage

// File: rtl/regfile.sv
// sMIPS general-purpose register file: two combinational read ports with
// write-through bypass from WB, one write port, and a bypass-free debug peek.
module regfile
   import regfile_pkg::*;
#(
   parameter int DATA_W  = RegDataBus,
   parameter int ADDR_W  = RegAddrBus,
   parameter int REG_NUM = RegNum
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   // No valid/ready here: every read is answered combinationally in the
   // cycle it is requested and every write retires on the next rising edge.

   logic [DATA_W-1:0] regs_q [REG_NUM];
   logic [DATA_W-1:0] regs_d [REG_NUM];

   logic in_reset;
   logic wr_active;

   assign in_reset  = (rst == RstEnable);
   assign wr_active = (we == WriteEnable) && (waddr != NOPRegAddr);

   always_comb begin
      regs_d = regs_q;
      if (wr_active) begin
         regs_d[waddr] = wdata;
      end
   end

   // A write coinciding with reset is dropped because the clear wins.
   always_ff @(posedge clk) begin
      if (in_reset) begin
         for (int i = 0; i < REG_NUM; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      rdata1 = '0;
      if (!in_reset && re1 && (raddr1 != NOPRegAddr)) begin
         if ((we == WriteEnable) && (raddr1 == waddr)) begin
            rdata1 = wdata;
         end else begin
            rdata1 = regs_q[raddr1];
         end
      end
   end

   always_comb begin
      rdata2 = '0;
      if (!in_reset && re2 && (raddr2 != NOPRegAddr)) begin
         if ((we == WriteEnable) && (raddr2 == waddr)) begin
            rdata2 = wdata;
         end else begin
            rdata2 = regs_q[raddr2];
         end
      end
   end

   always_comb begin
      dbg_data = '0;
      if (!in_reset) begin
         dbg_data = regs_q[dbg_addr];
      end
   end

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: directed vector table, a full write/read sweep and a
// randomized run scored against an array model of the register file.
module tb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        re1;
   logic [4:0]  raddr1;
   logic [31:0] rdata1;
   logic        re2;
   logic [4:0]  raddr2;
   logic [31:0] rdata2;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   regfile dut (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .re1      (re1),
      .raddr1   (raddr1),
      .rdata1   (rdata1),
      .re2      (re2),
      .raddr2   (raddr2),
      .rdata2   (rdata2),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        re1;
      logic [4:0]  ra1;
      logic        re2;
      logic [4:0]  ra2;
      logic [4:0]  dbg;
      logic [31:0] e1;
      logic [31:0] e2;
      logic [31:0] ed;
   } vec_t;

   vec_t        tbl[14];
   logic [31:0] model[32];
   logic [31:0] exp_q[$];
   int          n_vec  = 0;
   int          n_miss = 0;

   function automatic vec_t mk(logic r, logic w, logic [4:0] wa, logic [31:0] wd,
                               logic r1, logic [4:0] a1, logic r2, logic [4:0] a2,
                               logic [4:0] da, logic [31:0] x1, logic [31:0] x2,
                               logic [31:0] xd);
      vec_t v;
      v.rst = r;  v.we = w;   v.waddr = wa; v.wdata = wd;
      v.re1 = r1; v.ra1 = a1; v.re2 = r2;   v.ra2 = a2;
      v.dbg = da; v.e1 = x1;  v.e2 = x2;    v.ed = xd;
      return v;
   endfunction

   // Architectural read rule for one port, taken from the current inputs.
   function automatic logic [31:0] ref_read(logic en, logic [4:0] a);
      if (!rst || !en || a == 5'd0) return 32'h0;
      if (we && a == waddr) return wdata;
      return model[a];
   endfunction

   task automatic drive(vec_t v);
      rst = v.rst; we = v.we; waddr = v.waddr; wdata = v.wdata;
      re1 = v.re1; raddr1 = v.ra1; re2 = v.re2; raddr2 = v.ra2;
      dbg_addr = v.dbg;
   endtask

   task automatic check(string name, logic [31:0] act);
      logic [31:0] exp_v;
      exp_v = exp_q.pop_front();
      n_vec++;
      if (act !== exp_v) begin
         n_miss++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp_v);
      end
   endtask

   task automatic check_outputs(string tag);
      #1;
      check({tag, ".rdata1"}, rdata1);
      check({tag, ".rdata2"}, rdata2);
      check({tag, ".dbg_data"}, dbg_data);
   endtask

   // Commit the edge into the model, then return to the falling edge.
   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end else if (we && waddr != 5'd0) begin
         model[waddr] = wdata;
      end
      @(negedge clk);
   endtask

   initial begin
      vec_t v;
      rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
      re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0; dbg_addr = '0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;

      //            rst we wa  wdata         re1 a1 re2 a2 dbg  exp1          exp2          expdbg
      tbl[0]  = mk(0, 0, 0,  32'h0,        0,  0, 0,  0, 0,  32'h0,        32'h0,        32'h0);
      tbl[1]  = mk(1, 1, 5,  32'hDEADBEEF, 1,  5, 0,  0, 5,  32'hDEADBEEF, 32'h0,        32'h0);
      tbl[2]  = mk(1, 0, 0,  32'h0,        1,  5, 1,  5, 5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
      tbl[3]  = mk(0, 1, 3,  32'h55,       1,  5, 1,  3, 5,  32'h0,        32'h0,        32'h0);
      tbl[4]  = mk(1, 0, 0,  32'h0,        1,  5, 1,  3, 5,  32'h0,        32'h0,        32'h0);
      tbl[5]  = mk(1, 1, 7,  32'h12345678, 0,  7, 1,  7, 7,  32'h0,        32'h12345678, 32'h0);
      tbl[6]  = mk(1, 0, 0,  32'h0,        1,  7, 0,  7, 7,  32'h12345678, 32'h0,        32'h12345678);
      tbl[7]  = mk(1, 1, 0,  32'hFFFFFFFF, 1,  0, 1,  0, 0,  32'h0,        32'h0,        32'h0);
      tbl[8]  = mk(1, 0, 0,  32'h0,        1,  0, 1,  0, 0,  32'h0,        32'h0,        32'h0);
      tbl[9]  = mk(1, 1, 9,  32'h1,        0,  9, 0,  9, 9,  32'h0,        32'h0,        32'h0);
      tbl[10] = mk(1, 1, 9,  32'hA5A5A5A5, 1,  9, 1,  9, 9,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h1);
      tbl[11] = mk(1, 0, 0,  32'h0,        1,  9, 1,  7, 9,  32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5);
      tbl[12] = mk(1, 1, 3,  32'h77,       1,  3, 1,  4, 3,  32'h77,       32'h0,        32'h0);
      tbl[13] = mk(1, 0, 0,  32'h0,        1,  3, 1,  9, 3,  32'h77,       32'hA5A5A5A5, 32'h77);

      @(negedge clk);
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i]);
         exp_q.push_back(tbl[i].e1);
         exp_q.push_back(tbl[i].e2);
         exp_q.push_back(tbl[i].ed);
         check_outputs($sformatf("tbl%0d", i));
         tick();
      end

      // Sweep: r1..r31 get k*0x01010101, then every port-address pair is read.
      for (int k = 1; k < 32; k++) begin
         v = mk(1, 1, 5'(k), 32'(k) * 32'h01010101, 0, 0, 0, 0, 0, 0, 0, 0);
         drive(v);
         tick();
      end
      for (int a = 0; a < 32; a++) begin
         for (int b = 0; b < 32; b++) begin
            v = mk(1, 0, 0, 32'h0, 1, 5'(a), 1, 5'(b), 5'(a), 0, 0, 0);
            drive(v);
            exp_q.push_back(32'(a) * 32'h01010101);
            exp_q.push_back(32'(b) * 32'h01010101);
            exp_q.push_back(32'(a) * 32'h01010101);
            check_outputs($sformatf("sweep%0d_%0d", a, b));
            tick();
         end
      end

      // Random traffic with small address ranges so bypass hits are common.
      for (int n = 0; n < 800; n++) begin
         v = mk(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)), $urandom(),
                1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 31)), 0, 0, 0);
         drive(v);
         exp_q.push_back(ref_read(re1, raddr1));
         exp_q.push_back(ref_read(re2, raddr2));
         exp_q.push_back(rst ? model[dbg_addr] : 32'h0);
         check_outputs($sformatf("rand%0d", n));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
